mul_div_seq: RTL and testbench

Multi-cycle M-extension sequencer that computes unsigned MUL (low word), DIVU and REMU by driving the core's single-cycle `alu` for `DATA_WIDTH` iterations of shift-add or restoring-subtract. It sits beside the execute stage. It owns the ALU operand/operation inputs only while `busy` is high, and the core muxes the ALU between the normal datapath and this block. A start/busy/done handshake lets the hazard unit stall the pipeline for the duration of an operation.

---
 rtl/mul_div_seq.sv | 150 +++++++++++++++
 tb/tb_mul_div_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// mul_div_seq: multi-cycle unsigned MUL (low word) / DIVU / REMU sequencer.
// Borrows the core's single-cycle ALU for DATA_WIDTH iterations: ADD for
// shift-add multiply, SUB for restoring divide. ALU drive is combinational
// from state/registers and alu_result is consumed in the same cycle.
module mul_div_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [OPCODE_LENGTH-1:0] ALU_NOP = '0;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0100);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            op_q;
  // multiply registers
  logic [DATA_WIDTH-1:0] acc, mcand, mplier;
  // divide registers
  logic [DATA_WIDTH-1:0] rem, quot, dvsr;

  logic                  is_mul;
  logic [DATA_WIDTH-1:0] rem_sh;
  logic                  ge;
  logic [DATA_WIDTH-1:0] acc_nxt, rem_nxt, quot_nxt;

  assign is_mul = (op_q == OP_MUL);

  // Per-iteration next values; rem[W-1] stands in for the implicit bit W of
  // the shifted remainder, which always makes it >= dvsr.
  always_comb begin
    rem_sh   = {rem[DATA_WIDTH-2:0], quot[DATA_WIDTH-1]};
    ge       = rem[DATA_WIDTH-1] | (rem_sh >= dvsr);
    acc_nxt  = mplier[0] ? alu_result : acc;
    rem_nxt  = ge ? alu_result : rem_sh;
    quot_nxt = {quot[DATA_WIDTH-2:0], ge};
  end

  // ALU operand/operation drive; idle values whenever not iterating.
  always_comb begin
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_operation = ALU_NOP;
    if (state == S_RUN) begin
      if (is_mul) begin
        alu_src_a     = acc;
        alu_src_b     = mcand;
        alu_operation = ALU_ADD;
      end else begin
        alu_src_a     = rem_sh;
        alu_src_b     = dvsr;
        alu_operation = ALU_SUB;
      end
    end
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (op == OP_RSVD) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state  <= S_RUN;
              op_q   <= op;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              rem    <= '0;
              quot   <= a;
              dvsr   <= b;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_mul) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
          end
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            if (is_mul)               result <= acc_nxt;
            else if (op_q == OP_DIVU) result <= quot_nxt;
            else                      result <= rem_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: scoreboard bench for mul_div_seq with a behavioural ALU.
module tb_mul_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result, alu_src_a, alu_src_b, alu_result;
  logic [3:0]   alu_operation;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W-1:0] sb[$];

  mul_div_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_operation(alu_operation), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // single-cycle core ALU
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0010: alu_result = alu_src_a + alu_src_b;
      4'b0100: alu_result = alu_src_a - alu_src_b;
      default: alu_result = '0;
    endcase
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x * y;
      2'b01:   return (y == 0) ? '1 : x / y;
      2'b10:   return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  // Waits for done, checks ALU op during RUN, latency, result and release.
  task automatic wait_done(input string tag, input logic [1:0] o, input int exp_lat, input bit hold);
    int edges = 1;
    logic [W-1:0] exp;
    logic [3:0] exp_code;
    exp_code = (o == 2'b00) ? 4'b0010 : 4'b0100;
    while (!done && edges < 100) begin
      if (busy) chk({tag, "_aluop"}, W'(alu_operation), W'(exp_code));
      if (hold) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      edges++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, W'(edges), W'(exp_lat));
      start = 1'b0;
      return;
    end
    start = 1'b0;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk({tag, "_result"}, result, exp);
    chk({tag, "_latency"}, W'(edges), W'(exp_lat));
    chk({tag, "_busy_done"}, W'(busy), 1);
    @(negedge clk);
    chk({tag, "_done_clr"}, W'(done), 0);
    chk({tag, "_busy_clr"}, W'(busy), 0);
    chk({tag, "_held"}, result, exp);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(o, x, y, 1'b0);
    wait_done(tag, o, (o == 2'b11) ? 1 : 33, 1'b0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_srca", alu_src_a, 0);
    chk("rst_aluop", W'(alu_operation), 0);
    reset = 1'b0;
    @(negedge clk);

    run("mul_7x6", 2'b00, 32'd7, 32'd6);
    run("mul_wrap", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mul_ovf", 2'b00, 32'h8000_0000, 32'd2);
    run("divu_100_7", 2'b01, 32'd100, 32'd7);
    run("remu_100_7", 2'b10, 32'd100, 32'd7);
    run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run("remu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    run("divu_zero", 2'b01, 32'h1234, 32'd0);
    run("remu_zero", 2'b10, 32'h1234, 32'd0);
    run("rsvd", 2'b11, 32'h55, 32'h66);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom_range(1, 1000);
      run("rnd", 2'($urandom_range(0, 2)), x, y);
    end

    // start held high through RUN with churning operands
    d0 = done_cnt;
    start_op(2'b00, 32'd1000, 32'd77, 1'b1);
    wait_done("hold", 2'b00, 33, 1'b1);
    repeat (10) @(negedge clk);
    chk("hold_pulses", W'(done_cnt - d0), 1);

    // reset in RUN cycle 10 aborts without a done pulse
    start_op(2'b00, 32'd1234, 32'd567, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", W'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", W'(busy), 0);
    chk("abort_done", W'(done), 0);
    chk("abort_result", result, 0);
    chk("abort_aluop", W'(alu_operation), 0);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_nopulse", W'(done_cnt - d0), 0);
    run("mul_3x5", 2'b00, 32'd3, 32'd5);

    chk("sb_empty", W'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
